// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-memory responder: word RAM plus TX FIFO / STATUS / CYCLE MMIO window
// Define MISALIGN_CHK_EN to add sticky misalignment detection with store suppression.
module data_mem_responder #(
  parameter int          DATA_LEN      = 32,
  parameter int          DEPTH_WORDS   = 1024,
  parameter logic [31:0] MMIO_BASE     = 32'hFFFF_0000,
  parameter int          TX_FIFO_DEPTH = 8
) (
  input  logic                local_clk,
  input  logic                reset,
  input  logic [2:0]          mem_fn,
  input  logic [DATA_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] mem_out,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
`ifdef MISALIGN_CHK_EN
  ,
  output logic                misalign_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(TX_FIFO_DEPTH);
  localparam logic [FW:0] L_FIFO_DEPTH = (FW+1)'(TX_FIFO_DEPTH);

  localparam logic [2:0] FN_LB  = 3'd0;
  localparam logic [2:0] FN_LH  = 3'd1;
  localparam logic [2:0] FN_LW  = 3'd2;
  localparam logic [2:0] FN_LBU = 3'd3;
  localparam logic [2:0] FN_LHU = 3'd4;
  localparam logic [2:0] FN_SB  = 3'd5;
  localparam logic [2:0] FN_SH  = 3'd6;
  localparam logic [2:0] FN_SW  = 3'd7;

  localparam logic [13:0] REG_TX     = 14'd0;
  localparam logic [13:0] REG_STATUS = 14'd1;
  localparam logic [13:0] REG_CYCLE  = 14'd2;
  localparam logic [13:0] REG_CLEAR  = 14'd3;

  logic [DATA_LEN-1:0] r_mem [DEPTH_WORDS];
  logic [7:0]          r_fifo [TX_FIFO_DEPTH];
  logic [FW:0]         r_wptr;
  logic [FW:0]         r_rptr;
  logic                r_overflow;
  logic [DATA_LEN-1:0] r_cycle;

  logic [AW-1:0]       w_idx;
  logic [13:0]         w_mmio_reg;
  logic                w_is_mmio;
  logic                w_is_store;
  logic                w_misalign;
  logic                w_store_ok;
  logic                w_ram_we;
  logic [3:0]          w_be;
  logic [DATA_LEN-1:0] w_wlane;
  logic [FW:0]         w_count;
  logic [31:0]         w_count32;
  logic [3:0]          w_occ;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push_req;
  logic                w_push;
  logic                w_ovf_set;
  logic                w_ovf_clr;
  logic [DATA_LEN-1:0] w_status;
  logic [DATA_LEN-1:0] w_mmio_word;
  logic [DATA_LEN-1:0] w_rd_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;

  assign w_idx      = addr[AW+1:2];
  assign w_mmio_reg = addr[15:2];
  assign w_is_mmio  = (addr[31:16] == MMIO_BASE[31:16]);
  assign w_is_store = (mem_fn == FN_SB) || (mem_fn == FN_SH) || (mem_fn == FN_SW);

`ifdef MISALIGN_CHK_EN
  logic r_misalign;
  logic w_is_half;
  logic w_is_word;

  assign w_is_half  = (mem_fn == FN_LH) || (mem_fn == FN_LHU) || (mem_fn == FN_SH);
  assign w_is_word  = (mem_fn == FN_LW) || (mem_fn == FN_SW);
  assign w_misalign = (w_is_half && addr[0]) || (w_is_word && (addr[1:0] != 2'b00));

  always_ff @(posedge local_clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (w_misalign) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_err = r_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  // Every side effect below is gated by this: stores only, never in reset, never misaligned.
  assign w_store_ok = w_is_store && !reset && !w_misalign;
  assign w_ram_we   = w_store_ok && !w_is_mmio;

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = wdata;
    case (mem_fn)
      FN_SB: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wlane = {4{wdata[7:0]}};
      end
      FN_SH: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{wdata[15:0]}};
      end
      FN_SW:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge local_clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
        end
      end
    end
  end

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign w_count   = r_wptr - r_rptr;
  assign w_count32 = 32'(w_count);
  assign w_occ     = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (w_count == L_FIFO_DEPTH);
  assign tx_valid  = !w_empty;
  assign tx_data   = w_empty ? 8'h00 : r_fifo[r_rptr[FW-1:0]];
  assign w_pop     = tx_valid && tx_ready;

  // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_push_req = w_store_ok && w_is_mmio && (w_mmio_reg == REG_TX);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = w_store_ok && w_is_mmio && (w_mmio_reg == REG_CLEAR) && wdata[0];

  always_ff @(posedge local_clk) begin
    if (w_push) begin
      r_fifo[r_wptr[FW-1:0]] <= wdata[7:0];
    end
  end

  always_ff @(posedge local_clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_cycle    <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (FW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (FW+1)'(1);
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
      r_cycle <= r_cycle + DATA_LEN'(1);
    end
  end

  assign w_status = {{(DATA_LEN-8){1'b0}}, w_occ, 1'b0, r_overflow, w_empty, w_full};

  always_comb begin
    w_mmio_word = '0;
    case (w_mmio_reg)
      REG_STATUS: w_mmio_word = w_status;
      REG_CYCLE:  w_mmio_word = r_cycle;
      default:    w_mmio_word = '0;
    endcase
  end

  assign w_rd_word = w_is_mmio ? w_mmio_word : r_mem[w_idx];

  // Stores also present the addressed word, which is the pre-write value.
  always_comb begin
    w_byte = 8'h00;
    case (addr[1:0])
      2'd0: w_byte = w_rd_word[7:0];
      2'd1: w_byte = w_rd_word[15:8];
      2'd2: w_byte = w_rd_word[23:16];
      2'd3: w_byte = w_rd_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half  = addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    mem_out = w_rd_word;
    case (mem_fn)
      FN_LB:   mem_out = {{(DATA_LEN-8){w_byte[7]}}, w_byte};
      FN_LBU:  mem_out = {{(DATA_LEN-8){1'b0}}, w_byte};
      FN_LH:   mem_out = {{(DATA_LEN-16){w_half[15]}}, w_half};
      FN_LHU:  mem_out = {{(DATA_LEN-16){1'b0}}, w_half};
      default: mem_out = w_rd_word;
    endcase
    if (w_misalign) begin
      mem_out = '0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
// Covers MISALIGN_CHK_EN when the macro is defined for both files.
module tb_data_mem_responder;

  localparam int          DEPTH     = 1024;
  localparam int          RAM_BYTES = DEPTH * 4;
  localparam int          FDEPTH    = 8;
  localparam logic [31:0] MMIO      = 32'hFFFF_0000;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4;
  localparam logic [2:0] SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic        local_clk = 1'b0;
  logic        reset;
  logic [2:0]  mem_fn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
`ifdef MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  m_ram [RAM_BYTES];
  logic [7:0]  m_q [$];
  logic        m_ovf   = 1'b0;
  logic [31:0] m_cycle = 32'd0;

  always #5 local_clk = ~local_clk;

  data_mem_responder #(
    .DATA_LEN(32), .DEPTH_WORDS(DEPTH), .MMIO_BASE(MMIO), .TX_FIFO_DEPTH(FDEPTH)
  ) dut (
    .local_clk(local_clk),
    .reset(reset),
    .mem_fn(mem_fn),
    .addr(addr),
    .wdata(wdata),
    .mem_out(mem_out),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
`ifdef MISALIGN_CHK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  function automatic bit misaligned(input logic [2:0] fn, input logic [31:0] a);
    bit chk = 1'b0;
`ifdef MISALIGN_CHK_EN
    chk = 1'b1;
`endif
    if (!chk) return 1'b0;
    case (fn)
      LH, LHU, SH: return a[0];
      LW, SW:      return a[1:0] != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_status();
    int n = m_q.size();
    logic [3:0] occ = (n > 15) ? 4'hF : 4'(n);
    return {24'h0, occ, 1'b0, m_ovf, (n == 0), (n == FDEPTH)};
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] fn, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  by;
    logic [15:0] hw;
    int          b;
    if (misaligned(fn, a)) return 32'h0;
    if (a[31:16] == MMIO[31:16]) begin
      case (a[15:2])
        14'd1:   w = model_status();
        14'd2:   w = m_cycle;
        default: w = 32'h0;
      endcase
    end else begin
      b = int'(a & 32'(RAM_BYTES - 1)) & ~3;
      w = {m_ram[b+3], m_ram[b+2], m_ram[b+1], m_ram[b]};
    end
    by = 8'(w >> (8 * a[1:0]));
    hw = 16'(w >> (16 * a[1]));
    case (fn)
      LB:      return {{24{by[7]}}, by};
      LBU:     return {24'h0, by};
      LH:      return {{16{hw[15]}}, hw};
      LHU:     return {16'h0, hw};
      default: return w;
    endcase
  endfunction

  task automatic drive(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d);
    mem_fn = fn;
    addr   = a;
    wdata  = d;
    #1;
  endtask

  // Apply the request currently on the inputs to the model, then advance one edge.
  task automatic clk_edge();
    bit pop;
    int b;
    pop = (m_q.size() != 0) && tx_ready;
    if (reset) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_cycle = 32'd0;
    end else begin
      if (mem_fn >= SB && !misaligned(mem_fn, addr)) begin
        if (addr[31:16] != MMIO[31:16]) begin
          b = int'(addr & 32'(RAM_BYTES - 1));
          case (mem_fn)
            SB: m_ram[b] = wdata[7:0];
            SH: begin
              b = b & ~1;
              m_ram[b]   = wdata[7:0];
              m_ram[b+1] = wdata[15:8];
            end
            default: begin
              b = b & ~3;
              for (int i = 0; i < 4; i++) m_ram[b+i] = 8'(wdata >> (8 * i));
            end
          endcase
        end else if (addr[15:2] == 14'd0) begin
          if (pop) void'(m_q.pop_front());
          pop = 1'b0;
          if (m_q.size() < FDEPTH) m_q.push_back(wdata[7:0]);
          else m_ovf = 1'b1;
        end else if (addr[15:2] == 14'd3 && wdata[0]) begin
          m_ovf = 1'b0;
        end
      end
      if (pop) void'(m_q.pop_front());
      m_cycle = m_cycle + 32'd1;
    end
    @(posedge local_clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_ready = 1'b0;
    drive(LB, 32'h0, 32'h0);
    repeat (3) clk_edge();
    tests_run++;
    if (tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tx_valid got=%0b want=0", tx_valid);
    end
    tests_run++;
    if (tx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_tx_data got=%h want=00", tx_data);
    end
    drive(LW, MMIO + 32'h4, 32'h0);
    tests_run++;
    if (mem_out !== 32'h0000_0002) begin
      tests_failed++;
      $display("FAIL reset_status got=%h want=00000002", mem_out);
    end
    drive(LW, MMIO + 32'h8, 32'h0);
    tests_run++;
    if (mem_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_cycle got=%h want=00000000", mem_out);
    end
    reset = 1'b0;
    for (int w = 0; w < DEPTH; w++) begin
      drive(SW, 32'(w * 4), $urandom);
      clk_edge();
    end
  endtask

  task automatic test_load_widths();
    logic [2:0]  fns [5] = '{LB, LBU, LH, LHU, LW};
    logic [31:0] as  [5] = '{32'h11, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] exps[5] = '{32'hFFFF_FFF2, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_F2A3, 32'h8081_F2A3};
    drive(SW, 32'h10, 32'h8081_F2A3);
    clk_edge();
    for (int i = 0; i < 5; i++) begin
      drive(fns[i], as[i], 32'h0);
      tests_run++;
      if (mem_out !== exps[i]) begin
        tests_failed++;
        $display("FAIL load_width[%0d] got=%h want=%h", i, mem_out, exps[i]);
      end
      clk_edge();
    end
  endtask

  task automatic test_store_timing();
    drive(SB, 32'h10, 32'h0000_0055);
    tests_run++;
    if (mem_out !== 32'h8081_F2A3) begin
      tests_failed++;
      $display("FAIL same_cycle_prewrite got=%h want=8081f2a3", mem_out);
    end
    clk_edge();
    drive(LW, 32'h10, 32'h0);
    tests_run++;
    if (mem_out !== 32'h8081_F255) begin
      tests_failed++;
      $display("FAIL after_sb got=%h want=8081f255", mem_out);
    end
    drive(LW, 32'h10 + 32'(4 * DEPTH), 32'h0);
    tests_run++;
    if (mem_out !== 32'h8081_F255) begin
      tests_failed++;
      $display("FAIL alias got=%h want=8081f255", mem_out);
    end
    clk_edge();
  endtask

  task automatic test_random_ram();
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] exp;
    for (int i = 0; i < 300; i++) begin
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      if (a[31:16] == MMIO[31:16]) a[31:16] = 16'h0;
      drive(fn, a, $urandom);
      exp = exp_load(fn, a);
      tests_run++;
      if (mem_out !== exp) begin
        tests_failed++;
        $display("FAIL rand_ram[%0d] fn=%0d addr=%h got=%h want=%h", i, fn, a, mem_out, exp);
      end
      clk_edge();
    end
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(SB, MMIO, 32'(8'h41 + i));
      clk_edge();
    end
    drive(LW, MMIO + 32'h4, 32'h0);
    tests_run++;
    if (mem_out !== 32'h85 || mem_out !== model_status()) begin
      tests_failed++;
      $display("FAIL ovf_status got=%h want=00000085", mem_out);
    end
    tx_ready = 1'b1;
    drive(LB, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        tests_failed++;
        $display("FAIL ovf_drain[%0d] valid=%0b data=%h want=1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      clk_edge();
    end
    drive(LW, MMIO + 32'h4, 32'h0);
    tests_run++;
    if (mem_out !== 32'h06 || tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drained_status got=%h valid=%0b want=00000006/0", mem_out, tx_valid);
    end
    drive(SW, MMIO + 32'hC, 32'h1);
    clk_edge();
    drive(LW, MMIO + 32'h4, 32'h0);
    tests_run++;
    if (mem_out !== 32'h02) begin
      tests_failed++;
      $display("FAIL w1c_status got=%h want=00000002", mem_out);
    end
    tx_ready = 1'b0;
    clk_edge();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_seq [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h5A};
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(SB, MMIO, 32'(8'h10 + i));
      clk_edge();
    end
    tx_ready = 1'b1;
    drive(SB, MMIO, 32'h5A);
    tests_run++;
    if (tx_data !== 8'h10) begin
      tests_failed++;
      $display("FAIL full_head got=%h want=10", tx_data);
    end
    clk_edge();
    drive(LW, MMIO + 32'h4, 32'h0);
    tests_run++;
    if (mem_out !== 32'h81) begin
      tests_failed++;
      $display("FAIL full_pushpop_status got=%h want=00000081", mem_out);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL full_drain[%0d] valid=%0b data=%h want=1/%h", i, tx_valid, tx_data, exp_seq[i]);
      end
      clk_edge();
    end
    tests_run++;
    if (tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_drain_end valid=%0b want=0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_flush();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(SB, MMIO, 32'(8'hA0 + i));
      clk_edge();
    end
    drive(SW, 32'h40, 32'hCAFE_F00D);
    clk_edge();
    reset = 1'b1;
    drive(LB, 32'h0, 32'h0);
    clk_edge();
    drive(LW, MMIO + 32'h4, 32'h0);
    tests_run++;
    if (tx_valid !== 1'b0 || mem_out !== 32'h02) begin
      tests_failed++;
      $display("FAIL flush valid=%0b status=%h want=0/00000002", tx_valid, mem_out);
    end
    reset = 1'b0;
    drive(LB, 32'h0, 32'h0);
    repeat (5) clk_edge();
    drive(LW, MMIO + 32'h8, 32'h0);
    tests_run++;
    if (mem_out !== 32'd5 || mem_out !== m_cycle) begin
      tests_failed++;
      $display("FAIL cycle_after_reset got=%0d want=5", mem_out);
    end
    drive(LW, 32'h40, 32'h0);
    tests_run++;
    if (mem_out !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL ram_retained got=%h want=cafef00d", mem_out);
    end
    clk_edge();
  endtask

  task automatic test_random_fifo();
    int          r;
    logic [31:0] exp;
    logic [7:0]  exp_head;
    for (int i = 0; i < 300; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 5)       drive(3'(SB + $urandom_range(0, 2)), MMIO, $urandom);
      else if (r == 5) drive(SW, MMIO + 32'hC, $urandom);
      else if (r < 8)  drive(LW, MMIO + 32'h4, 32'h0);
      else             drive(LB, $urandom & 32'h0000_0FFF, 32'h0);
      exp_head = (m_q.size() != 0) ? m_q[0] : 8'h00;
      tests_run++;
      if (tx_valid !== (m_q.size() != 0) || tx_data !== exp_head) begin
        tests_failed++;
        $display("FAIL rand_fifo_head[%0d] valid=%0b data=%h want=%0b/%h", i, tx_valid, tx_data, (m_q.size() != 0), exp_head);
      end
      exp = exp_load(mem_fn, addr);
      tests_run++;
      if (mem_out !== exp) begin
        tests_failed++;
        $display("FAIL rand_fifo_read[%0d] fn=%0d addr=%h got=%h want=%h", i, mem_fn, addr, mem_out, exp);
      end
      clk_edge();
    end
    tx_ready = 1'b0;
  endtask

`ifdef MISALIGN_CHK_EN
  task automatic test_misalign();
    logic [31:0] exp;
    reset = 1'b1;
    drive(LB, 32'h0, 32'h0);
    clk_edge();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(LB, ($urandom & 32'h0000_0FFF) | 32'h1, 32'h0);
      clk_edge();
      tests_run++;
      if (misalign_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL bubble_misalign[%0d] got=%0b want=0", i, misalign_err);
      end
    end
    exp = exp_load(LW, 32'h20);
    drive(SW, 32'h22, 32'hDEAD_BEEF);
    clk_edge();
    tests_run++;
    if (misalign_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL misalign_set got=%0b want=1", misalign_err);
    end
    drive(LW, 32'h20, 32'h0);
    tests_run++;
    if (mem_out !== exp) begin
      tests_failed++;
      $display("FAIL misalign_store_suppressed got=%h want=%h", mem_out, exp);
    end
    drive(LH, 32'h21, 32'h0);
    tests_run++;
    if (mem_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL misalign_load_zero got=%h want=00000000", mem_out);
    end
    clk_edge();
  endtask
`endif

  initial begin
    reset    = 1'b1;
    tx_ready = 1'b0;
    mem_fn   = LB;
    addr     = 32'h0;
    wdata    = 32'h0;
    test_reset();
    test_load_widths();
    test_store_timing();
    test_random_ram();
    test_fifo_overflow();
    test_full_push_pop();
    test_reset_flush();
    test_random_fifo();
`ifdef MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
